alarm_controller: RTL
=====================

Name: alarm_controller

Overview:
- Downstream consumer of the 4-digit code checker's 2-bit result (OK/ERROR/NOKEY).
- Synchronises that result into the system clock domain and turns each completed code entry into a one-shot event.
- Runs the home-alarm arming FSM: exit/entry delays, siren drive, and wrong-code lockout.
- Drives the siren, armed LED and status outputs.

Parameters:
- N_SENSORS, 4, number of zone sensor inputs
- EXIT_CYCLES, 8, cycles spent in EXIT_DELAY
- ENTRY_CYCLES, 6, cycles spent in ENTRY_DELAY
- SIREN_CYCLES, 20, cycles spent in ALARM before auto re-arm
- MAX_ERRORS, 3, consecutive ERROR results that trigger escalation
- LOCKOUT_CYCLES, 16, cycles code events are ignored after escalation while disarmed

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- code_result  in  2  checker result, asynchronous to clk: 0=OK, 2=ERROR, 3=NOKEY
- sensor  in  N_SENSORS  zone contacts, active-high, asynchronous
- siren  out  1  siren drive
- armed  out  1  high in ARMED, ENTRY_DELAY, ALARM
- beep  out  1  high during EXIT_DELAY and ENTRY_DELAY
- locked  out  1  lockout active
- err_cnt  out  $clog2(MAX_ERRORS+1)  consecutive error count
- state  out  3  current FSM state encoding

Behaviour:
- Reset:
  - Reset is one clock with asynchronous, active-low reset (rst_n).
  - While rst_n=0: state=DISARMED; siren, armed, beep, locked, err_cnt = 0; sync flops cleared to NOKEY; sensor syncs cleared to 0.
  - Reset mid-delay or mid-alarm aborts immediately.
- code_result synchronisation:
  - 2-flop sync, then a stability filter: a value is accepted only when the sync output is equal on 2 consecutive clocks. This rejects the transient 01/10 codes seen while the bus changes.
  - accepted value 1 is treated as NOKEY.
  - Event rule: code_ok / code_err pulses for exactly 1 clk when the accepted value changes from NOKEY to OK or ERROR. A held OK/ERROR never re-fires.
  - Latency: state and outputs update on the 4th rising edge counting the first edge that samples the new value.
- sensor: 2-flop sync per bit; trip = OR of the synchronised bits.
- FSM:
  - DISARMED: code_ok -> EXIT_DELAY.
  - EXIT_DELAY: code_ok -> DISARMED; timer expiry -> ARMED; trip ignored.
  - ARMED: code_ok -> DISARMED; trip -> ENTRY_DELAY.
  - ENTRY_DELAY: code_ok -> DISARMED; timer expiry -> ALARM.
  - ALARM: siren=1; code_ok -> DISARMED; timer expiry -> ARMED (if trip is still high, ENTRY_DELAY follows next cycle).
- Timer:
  - Loaded with N-1 on state entry, decrements each cycle, expires at 0. Each timed state lasts exactly N cycles.
  - Width = $clog2 of the largest cycle parameter.
- Error count:
  - code_err increments err_cnt, saturating at MAX_ERRORS.
  - code_ok clears err_cnt.
  - When err_cnt reaches MAX_ERRORS:
    - in ARMED or ENTRY_DELAY -> ALARM immediately.
    - in DISARMED or EXIT_DELAY -> locked=1 for LOCKOUT_CYCLES. The FSM continues running (exit delay keeps counting).
  - In either case err_cnt is cleared.
- Lockout: while locked=1, code_ok and code_err are discarded. The filter still tracks the input, so a held value does not fire when lockout ends.
- Priorities:
  - code_ok beats timer expiry and trip in the same cycle.
  - MAX_ERRORS escalation beats timer expiry.

Optional Feature:
- Macro: ALARM_TAMPER_EN.
- With the macro defined:
  - Adds input port tamper (1 bit, active-high, 2-flop synchronised).
  - tamper=1 forces ALARM from any state, including DISARMED.
  - tamper has highest priority, above code_ok.
  - While tamper stays high, ALARM does not time out, and code_ok does not leave ALARM.
- Without the macro: no tamper port; behaviour is exactly as above.

Decomposition:
- Package alarm_pkg holds:
  - result constants CODE_OK=2'd0, CODE_ERROR=2'd2, CODE_NOKEY=2'd3.
  - state encoding DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
- One sub-module, code_result_sync: 2-flop sync, stability filter, and the NOKEY->result event pulses code_ok/code_err.

Test Plan:
- Arm and disarm: drive code_result 3->0 -> state EXIT_DELAY 4 edges later; beep=1 for 8 cycles; ARMED with armed=1. Then 3->0 -> DISARMED, armed=0.
- Intrusion: ARMED, sensor[2]=1 -> ENTRY_DELAY, beep=1 for 6 cycles -> ALARM, siren=1 for 20 cycles -> ARMED (sensor already released).
- Glitch rejection: hold code_result at 2'b10 for 1 clk during a 3->0 transition -> no err_cnt change; a single code_ok fires.
- Escalation while armed: 3 ERROR entries (each via NOKEY) in ARMED -> ALARM on the 3rd; err_cnt returns to 0.
- Lockout while disarmed: 3 ERRORs -> locked=1 for 16 cycles; an OK entry inside the window is ignored (state stays DISARMED); an OK after the window arms.
- Simultaneity and reset: code_ok lands on the ENTRY_DELAY expiry cycle -> DISARMED, siren stays 0. Pulse rst_n=0 during ALARM -> all outputs 0 asynchronously, state=DISARMED.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared result codes, FSM state encoding and helpers
// for the home-alarm controller.
package alarm_pkg;

   localparam logic [1:0] CODE_OK    = 2'd0;
   localparam logic [1:0] CODE_ERROR = 2'd2;
   localparam logic [1:0] CODE_NOKEY = 2'd3;

   typedef enum logic [2:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      ALARM       = 3'd4
   } state_e;

   // 2'b01 never means a real result; fold it into NOKEY
   function automatic logic [1:0] norm_code(logic [1:0] c);
      return (c == 2'd1) ? CODE_NOKEY : c;
   endfunction

endpackage

// File: rtl/code_result_sync.sv
// Brings the checker result into clk, rejects bus-transition codes
// and pulses code_ok/code_err once per NOKEY->result step.
module code_result_sync
   import alarm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] code_result,
   output logic       code_ok,
   output logic       code_err
);

   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] prev_q, prev_d;
   logic [1:0] acc_q, acc_d;
   logic [1:0] cur;
   logic       stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= CODE_NOKEY;
         sync2_q <= CODE_NOKEY;
         prev_q  <= CODE_NOKEY;
         acc_q   <= CODE_NOKEY;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      sync1_d  = code_result;
      sync2_d  = sync1_q;
      cur      = norm_code(sync2_q);
      prev_d   = cur;
      stable   = (cur == prev_q);
      acc_d    = stable ? cur : acc_q;
      code_ok  = stable && (acc_q == CODE_NOKEY) && (cur == CODE_OK);
      code_err = stable && (acc_q == CODE_NOKEY) && (cur == CODE_ERROR);
   end

endmodule

// File: rtl/alarm_controller.sv
// Home-alarm arming FSM with delays, siren and wrong-code lockout.
// Define ALARM_TAMPER_EN to add the tamper input.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int N_SENSORS      = 4,
   parameter int EXIT_CYCLES    = 8,
   parameter int ENTRY_CYCLES   = 6,
   parameter int SIREN_CYCLES   = 20,
   parameter int MAX_ERRORS     = 3,
   parameter int LOCKOUT_CYCLES = 16
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [1:0]                        code_result,
   input  logic [N_SENSORS-1:0]              sensor,
`ifdef ALARM_TAMPER_EN
   input  logic                              tamper,
`endif
   output logic                              siren,
   output logic                              armed,
   output logic                              beep,
   output logic                              locked,
   output logic [$clog2(MAX_ERRORS+1)-1:0]   err_cnt,
   output logic [2:0]                        state
);

   localparam int T_A   = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
   localparam int T_MAX = (T_A > SIREN_CYCLES) ? T_A : SIREN_CYCLES;
   localparam int TW    = $clog2(T_MAX);
   localparam int EW    = $clog2(MAX_ERRORS+1);
   localparam int LW    = $clog2(LOCKOUT_CYCLES+1);

   state_e                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [EW-1:0]          err_q, err_d;
   logic                   locked_q, locked_d;
   logic [LW-1:0]          lcnt_q, lcnt_d;
   logic [N_SENSORS-1:0]   sens1_q, sens1_d, sens2_q, sens2_d;
   logic                   code_ok, code_err;
   logic                   ok, err, trip, esc_alarm, expired, tamper_s;

   code_result_sync u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .code_result (code_result),
      .code_ok     (code_ok),
      .code_err    (code_err)
   );

`ifdef ALARM_TAMPER_EN
   logic tamp1_q, tamp1_d, tamp2_q, tamp2_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tamp1_q <= 1'b0;
         tamp2_q <= 1'b0;
      end else begin
         tamp1_q <= tamp1_d;
         tamp2_q <= tamp2_d;
      end
   end

   always_comb begin
      tamp1_d  = tamper;
      tamp2_d  = tamp1_q;
      tamper_s = tamp2_q;
   end
`else
   assign tamper_s = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DISARMED;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q  <= '0;
         err_q    <= '0;
         locked_q <= 1'b0;
         lcnt_q   <= '0;
         sens1_q  <= '0;
         sens2_q  <= '0;
      end else begin
         timer_q  <= timer_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         lcnt_q   <= lcnt_d;
         sens1_q  <= sens1_d;
         sens2_q  <= sens2_d;
      end
   end

   function automatic logic [TW-1:0] load(state_e s);
      case (s)
         EXIT_DELAY:  return TW'(EXIT_CYCLES-1);
         ENTRY_DELAY: return TW'(ENTRY_CYCLES-1);
         ALARM:       return TW'(SIREN_CYCLES-1);
         default:     return '0;
      endcase
   endfunction

   // Error counting and lockout; events are dropped while locked
   always_comb begin
      sens1_d   = sensor;
      sens2_d   = sens1_q;
      trip      = |sens2_q;
      ok        = code_ok & ~locked_q;
      err       = code_err & ~locked_q;
      err_d     = err_q;
      locked_d  = locked_q;
      lcnt_d    = lcnt_q;
      esc_alarm = 1'b0;
      if (locked_q) begin
         if (lcnt_q == '0) locked_d = 1'b0;
         else              lcnt_d   = lcnt_q - LW'(1);
      end
      if (ok) begin
         err_d = '0;
      end else if (err) begin
         if (err_q >= EW'(MAX_ERRORS-1)) begin
            case (state_q)
               ARMED, ENTRY_DELAY: begin
                  esc_alarm = 1'b1;
                  err_d     = '0;
               end
               DISARMED, EXIT_DELAY: begin
                  locked_d = 1'b1;
                  lcnt_d   = LW'(LOCKOUT_CYCLES-1);
                  err_d    = '0;
               end
               default: err_d = EW'(MAX_ERRORS);
            endcase
         end else begin
            err_d = err_q + EW'(1);
         end
      end
   end

   always_comb begin
      expired = (timer_q == '0);
      state_d = state_q;
      if (tamper_s) begin
         state_d = ALARM;
      end else if (ok) begin
         state_d = (state_q == DISARMED) ? EXIT_DELAY : DISARMED;
      end else if (esc_alarm) begin
         state_d = ALARM;
      end else begin
         case (state_q)
            EXIT_DELAY:  if (expired) state_d = ARMED;
            ARMED:       if (trip)    state_d = ENTRY_DELAY;
            ENTRY_DELAY: if (expired) state_d = ALARM;
            ALARM:       if (expired) state_d = ARMED;
            default:     state_d = state_q;
         endcase
      end
      // Held tamper keeps reloading so the siren cannot time out
      if ((state_d != state_q) || tamper_s) timer_d = load(state_d);
      else if (!expired)                    timer_d = timer_q - TW'(1);
      else                                  timer_d = timer_q;
   end

   always_comb begin
      siren   = (state_q == ALARM);
      armed   = (state_q == ARMED) || (state_q == ENTRY_DELAY) ||
                (state_q == ALARM);
      beep    = (state_q == EXIT_DELAY) || (state_q == ENTRY_DELAY);
      locked  = locked_q;
      err_cnt = err_q;
      state   = state_q;
   end

endmodule
